// File: rtl/afio_ctrl_pkg.sv
// Shared definitions for the AFIO pin-mux sequencer: register map, FSM states, bit indices.
// No logic and no latency.
// No flow control.
package afio_ctrl_pkg;

   localparam logic [5:0] OFF_AFC_SH   = 6'h00;
   localparam logic [5:0] OFF_DIR_SH   = 6'h04;
   localparam logic [5:0] OFF_PM_SH_LO = 6'h08;
   localparam logic [5:0] OFF_PM_SH_HI = 6'h0C;
   localparam logic [5:0] OFF_PS_SH_LO = 6'h10;
   localparam logic [5:0] OFF_PS_SH_HI = 6'h14;
   localparam logic [5:0] OFF_CTRL     = 6'h18;
   localparam logic [5:0] OFF_STATUS   = 6'h1C;
   localparam logic [5:0] OFF_DEAD     = 6'h20;
   localparam logic [5:0] OFF_AFC_LIVE = 6'h24;

   localparam int CTRL_APPLY  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLOAT  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] afc;
      logic [31:0] dir;
      logic [63:0] pm;
      logic [63:0] ps;
   } cfg_t;

endpackage

// File: rtl/afio_ctrl_apb.sv
// APB register file: shadow config, CTRL/STATUS/DEAD, apply pulse and error response.
// Writes commit on the access-phase edge; PRDATA/PSLVERR are combinational.
// No wait states; writes that would disturb a running handover are dropped with PSLVERR.
module afio_ctrl_apb
   import afio_ctrl_pkg::*;
#(
   parameter logic [7:0] DEAD_RST = 8'd4
) (
   input  logic        core_clk,
   input  logic        arst_n,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [5:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pslverr,
   input  logic        busy,
   input  logic        done_set,
   input  logic [31:0] afc_live,
   output cfg_t        shadow,
   output logic [7:0]  dead,
   output logic        irq_en,
   output logic        done,
   output logic        apply_vld
);

   logic [5:0] addr;
   logic       wr_en;
   logic       ctrl_sel;
   logic       locked_reg;
   logic       blocked;

   assign addr     = paddr & 6'b111100;
   assign wr_en    = psel & penable & pwrite;
   assign ctrl_sel = (addr == OFF_CTRL);

   // Registers that must stay frozen while a handover is running.
   always_comb begin
      locked_reg = 1'b0;
      case (addr)
         OFF_AFC_SH, OFF_DIR_SH, OFF_PM_SH_LO, OFF_PM_SH_HI,
         OFF_PS_SH_LO, OFF_PS_SH_HI, OFF_DEAD: locked_reg = 1'b1;
         default: locked_reg = 1'b0;
      endcase
   end

   assign blocked   = busy & (locked_reg | (ctrl_sel & pwdata[CTRL_APPLY]));
   assign pslverr   = wr_en & blocked;
   assign apply_vld = wr_en & ctrl_sel & pwdata[CTRL_APPLY] & ~busy;

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         shadow <= '0;
         dead   <= DEAD_RST;
         irq_en <= 1'b0;
         done   <= 1'b0;
      end else begin
         if (wr_en && !busy) begin
            case (addr)
               OFF_AFC_SH:   shadow.afc       <= pwdata;
               OFF_DIR_SH:   shadow.dir       <= pwdata;
               OFF_PM_SH_LO: shadow.pm[31:0]  <= pwdata;
               OFF_PM_SH_HI: shadow.pm[63:32] <= pwdata;
               OFF_PS_SH_LO: shadow.ps[31:0]  <= pwdata;
               OFF_PS_SH_HI: shadow.ps[63:32] <= pwdata;
               OFF_DEAD:     dead             <= pwdata[7:0];
               default: ;
            endcase
         end
         if (wr_en && ctrl_sel)
            irq_en <= pwdata[CTRL_IRQ_EN];
         // A completion on the same edge as a clear must not be lost.
         if (done_set)
            done <= 1'b1;
         else if (wr_en && (addr == OFF_STATUS) && pwdata[STAT_DONE])
            done <= 1'b0;
      end
   end

   always_comb begin
      prdata = '0;
      case (addr)
         OFF_AFC_SH:   prdata = shadow.afc;
         OFF_DIR_SH:   prdata = shadow.dir;
         OFF_PM_SH_LO: prdata = shadow.pm[31:0];
         OFF_PM_SH_HI: prdata = shadow.pm[63:32];
         OFF_PS_SH_LO: prdata = shadow.ps[31:0];
         OFF_PS_SH_HI: prdata = shadow.ps[63:32];
         OFF_CTRL:     prdata[CTRL_IRQ_EN] = irq_en;
         OFF_STATUS: begin
            prdata[STAT_BUSY] = busy;
            prdata[STAT_DONE] = done;
         end
         OFF_DEAD:     prdata[7:0] = dead;
         OFF_AFC_LIVE: prdata = afc_live;
         default:      prdata = '0;
      endcase
   end

endmodule

// File: rtl/afio_ctrl.sv
// AFIO pin-mux sequencer: float changed pins, switch owner, restore direction.
// Owner switch at E0+DEAD+1, restore/DONE at E0+2*DEAD+2 after the APPLY edge.
// APB never stalls (PREADY=1); busy blocks config writes instead.
module afio_ctrl
   import afio_ctrl_pkg::*;
#(
   parameter logic [7:0] DEAD_RST = 8'd4
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [5:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [31:0] GPIO_AFC,
   output logic [31:0] GPIO_DIR,
   output logic [63:0] GPIO_PM,
   output logic [63:0] GPIO_PS,
   output logic        busy,
   output logic        irq
);

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   cfg_t        live, live_nxt;
   cfg_t        shadow;
   logic [7:0]  dead;
   logic [31:0] chg;
   logic        busy_nxt;
   logic        done_set;
   logic        apply_vld;
   logic        irq_en;
   logic        done;

   afio_ctrl_apb #(.DEAD_RST(DEAD_RST)) u_apb (
      .core_clk  (PCLK),
      .arst_n    (PRESETn),
      .psel      (PSEL),
      .penable   (PENABLE),
      .pwrite    (PWRITE),
      .paddr     (PADDR),
      .pwdata    (PWDATA),
      .prdata    (PRDATA),
      .pslverr   (PSLVERR),
      .busy      (busy),
      .done_set  (done_set),
      .afc_live  (live.afc),
      .shadow    (shadow),
      .dead      (dead),
      .irq_en    (irq_en),
      .done      (done),
      .apply_vld (apply_vld)
   );

   assign chg = live.afc ^ shadow.afc;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (apply_vld && (chg != '0)) state_nxt = FLOAT;
         FLOAT:   if (cnt == '0) state_nxt = SETTLE;
         SETTLE:  if (cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      live_nxt = live;
      cnt_nxt  = cnt;
      busy_nxt = busy;
      done_set = 1'b0;
      case (state)
         IDLE: begin
            if (apply_vld) begin
               if (chg != '0) begin
                  live_nxt.dir = live.dir & ~chg;
                  cnt_nxt      = dead;
                  busy_nxt     = 1'b1;
               end else begin
                  // No owner changes, so nothing can glitch: apply in one edge.
                  live_nxt.dir = shadow.dir;
                  live_nxt.pm  = shadow.pm;
                  live_nxt.ps  = shadow.ps;
                  done_set     = 1'b1;
               end
            end
         end
         FLOAT: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 8'd1;
            end else begin
               live_nxt.afc = shadow.afc;
               live_nxt.pm  = shadow.pm;
               live_nxt.ps  = shadow.ps;
               cnt_nxt      = dead;
            end
         end
         SETTLE: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 8'd1;
            end else begin
               live_nxt.dir = shadow.dir;
               busy_nxt     = 1'b0;
               done_set     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         live <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else begin
         live <= live_nxt;
         cnt  <= cnt_nxt;
         busy <= busy_nxt;
      end
   end

   assign GPIO_AFC = live.afc;
   assign GPIO_DIR = live.dir;
   assign GPIO_PM  = live.pm;
   assign GPIO_PS  = live.ps;
   assign PREADY   = 1'b1;
   assign irq      = done & irq_en;

endmodule

// File: tb/tb_afio_ctrl.sv
// Scoreboard bench for afio_ctrl: directed APB sequences push expectations,
// a negedge monitor pops them on APB access phases and on GPIO sample strobes.
module tb_afio_ctrl;

   logic        PCLK    = 1'b0;
   logic        PRESETn = 1'b0;
   logic        PSEL    = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE  = 1'b0;
   logic [5:0]  PADDR   = '0;
   logic [31:0] PWDATA  = '0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [31:0] GPIO_AFC;
   logic [31:0] GPIO_DIR;
   logic [63:0] GPIO_PM;
   logic [63:0] GPIO_PS;
   logic        busy;
   logic        irq;

   afio_ctrl #(.DEAD_RST(8'd4)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .GPIO_AFC(GPIO_AFC),
      .GPIO_DIR(GPIO_DIR), .GPIO_PM(GPIO_PM), .GPIO_PS(GPIO_PS),
      .busy(busy), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   localparam int K_RD  = 0;
   localparam int K_ERR = 1;
   localparam int K_SIG = 2;
   localparam int S_AFC = 0, S_DIR = 1, S_PM = 2, S_PS = 3, S_BUSY = 4, S_IRQ = 5;

   localparam logic [5:0] A_AFC = 6'h00, A_DIR = 6'h04, A_PML = 6'h08, A_PMH = 6'h0C;
   localparam logic [5:0] A_PSL = 6'h10, A_CTRL = 6'h18, A_STAT = 6'h1C, A_DEAD = 6'h20;
   localparam logic [5:0] A_LIVE = 6'h24, A_UNM = 6'h28;

   typedef struct {
      int          kind;
      int          sel;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic probe = 1'b0;

   function automatic logic [63:0] sig_val(int s);
      case (s)
         S_AFC:   return {32'b0, GPIO_AFC};
         S_DIR:   return {32'b0, GPIO_DIR};
         S_PM:    return GPIO_PM;
         S_PS:    return GPIO_PS;
         S_BUSY:  return {63'b0, busy};
         S_IRQ:   return {63'b0, irq};
         default: return '0;
      endcase
   endfunction

   function automatic string cname(exp_t e);
      string nm;
      case (e.kind)
         K_RD:    nm = $sformatf("prdata@%02h", e.sel);
         K_ERR:   nm = $sformatf("pslverr@%02h", e.sel);
         default: begin
            case (e.sel)
               S_AFC:   nm = "gpio_afc";
               S_DIR:   nm = "gpio_dir";
               S_PM:    nm = "gpio_pm";
               S_PS:    nm = "gpio_ps";
               S_BUSY:  nm = "busy";
               default: nm = "irq";
            endcase
         end
      endcase
      return nm;
   endfunction

   task automatic check(exp_t e, logic [63:0] act);
      n_cmp++;
      if (act !== e.val) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", cname(e), act, e.val, $time);
      end
   endtask

   // Monitor: consumes expectations when the DUT answers an APB access or on a sample strobe.
   always @(negedge PCLK) begin : monitor
      exp_t e;
      if (PSEL && PENABLE) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL apb_unexpected addr=%02h t=%0t", PADDR, $time);
         end else begin
            e = sb.pop_front();
            if (e.kind == K_RD) check(e, {32'b0, PRDATA});
            else                check(e, {63'b0, PSLVERR});
         end
      end
      if (probe) begin
         while (sb.size() > 0 && sb[0].kind == K_SIG) begin
            e = sb.pop_front();
            check(e, sig_val(e.sel));
         end
      end
   end

   task automatic push(int k, int s, logic [63:0] v);
      exp_t e;
      e.kind = k;
      e.sel  = s;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic apb_wr(logic [5:0] a, logic [31:0] d, logic err);
      push(K_ERR, int'(a), {63'b0, err});
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_rd(logic [5:0] a, logic [31:0] d);
      push(K_RD, int'(a), {32'b0, d});
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
      @(posedge PCLK); #1 PENABLE = 1'b1;
      @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic exp_sig(int s, logic [63:0] v);
      push(K_SIG, s, v);
   endtask

   // Samples the state left by the most recent edge, returns 1ns after the next one.
   task automatic sample();
      probe = 1'b1;
      @(negedge PCLK); #1 probe = 1'b0;
      @(posedge PCLK); #1;
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1'b1;

      // Reset state
      exp_sig(S_AFC, 0); exp_sig(S_DIR, 0); exp_sig(S_PM, 0); exp_sig(S_PS, 0);
      exp_sig(S_BUSY, 0); exp_sig(S_IRQ, 0);
      sample();
      apb_rd(A_DEAD, 32'h4);
      apb_rd(A_STAT, 32'h0);
      apb_rd(A_CTRL, 32'h0);
      apb_wr(A_UNM, 32'h123, 1'b0);
      apb_rd(A_UNM, 32'h0);

      // No-change apply: takes effect on the APPLY edge itself
      apb_wr(A_DIR, 32'h11, 1'b0);
      apb_wr(A_PML, 32'h5, 1'b0);
      apb_wr(A_CTRL, 32'h1, 1'b0);
      exp_sig(S_DIR, 32'h11); exp_sig(S_PM, 64'h5); exp_sig(S_BUSY, 0); exp_sig(S_AFC, 0);
      sample();
      exp_sig(S_BUSY, 0);
      sample();
      apb_rd(A_STAT, 32'h2);
      apb_wr(A_STAT, 32'h2, 1'b0);
      apb_rd(A_STAT, 32'h0);

      // Full handover, DEAD = 2
      apb_wr(A_DEAD, 32'h2, 1'b0);
      apb_wr(A_AFC, 32'hF0, 1'b0);
      apb_wr(A_DIR, 32'h0F, 1'b0);
      apb_wr(A_PMH, 32'hA5A5_A5A5, 1'b0);
      apb_wr(A_PSL, 32'h3C, 1'b0);
      apb_rd(A_AFC, 32'hF0);
      apb_wr(A_CTRL, 32'h1, 1'b0);                    // E0
      exp_sig(S_DIR, 32'h01); exp_sig(S_BUSY, 1); exp_sig(S_AFC, 0); exp_sig(S_PM, 64'h5);
      sample();                                        // after E0
      cyc(1);
      exp_sig(S_AFC, 0); exp_sig(S_BUSY, 1);
      sample();                                        // after E0+2
      exp_sig(S_AFC, 32'hF0); exp_sig(S_PM, 64'hA5A5_A5A5_0000_0005);
      exp_sig(S_PS, 64'h3C); exp_sig(S_DIR, 32'h01);
      sample();                                        // after E0+3
      cyc(1);
      exp_sig(S_DIR, 32'h01); exp_sig(S_BUSY, 1);
      sample();                                        // after E0+5
      exp_sig(S_DIR, 32'h0F); exp_sig(S_BUSY, 0);
      sample();                                        // after E0+6
      apb_rd(A_STAT, 32'h2);
      apb_rd(A_LIVE, 32'hF0);

      // Busy lockout, DEAD = 20
      apb_wr(A_STAT, 32'h2, 1'b0);
      apb_wr(A_DIR, 32'h300, 1'b0);
      apb_wr(A_DEAD, 32'd20, 1'b0);
      apb_wr(A_AFC, 32'hF00, 1'b0);
      apb_wr(A_CTRL, 32'h1, 1'b0);                    // E0
      apb_wr(A_AFC, 32'hDEAD, 1'b1);
      apb_wr(A_STAT, 32'h2, 1'b0);
      apb_wr(A_DEAD, 32'h0, 1'b1);
      apb_wr(A_CTRL, 32'h2, 1'b0);
      apb_wr(A_CTRL, 32'h3, 1'b1);
      apb_wr(A_PML, 32'h77, 1'b1);
      apb_wr(A_UNM, 32'h1, 1'b0);
      apb_rd(A_AFC, 32'hF00);
      apb_rd(A_DEAD, 32'd20);
      apb_rd(A_STAT, 32'h1);
      apb_rd(A_CTRL, 32'h2);
      apb_rd(A_PML, 32'h5);
      cyc(25);
      apb_rd(A_STAT, 32'h2);
      exp_sig(S_IRQ, 1); exp_sig(S_AFC, 32'hF00); exp_sig(S_DIR, 32'h300);
      exp_sig(S_PM, 64'hA5A5_A5A5_0000_0005); exp_sig(S_BUSY, 0);
      sample();
      apb_wr(A_STAT, 32'h2, 1'b0);
      exp_sig(S_IRQ, 0);
      sample();

      // Interrupt with DEAD = 0
      apb_wr(A_DEAD, 32'h0, 1'b0);
      apb_wr(A_AFC, 32'h0, 1'b0);
      apb_wr(A_DIR, 32'h1, 1'b0);
      apb_wr(A_CTRL, 32'h3, 1'b0);                    // E0
      exp_sig(S_BUSY, 1); exp_sig(S_DIR, 0); exp_sig(S_IRQ, 0); exp_sig(S_AFC, 32'hF00);
      sample();
      exp_sig(S_AFC, 0); exp_sig(S_BUSY, 1); exp_sig(S_DIR, 0); exp_sig(S_IRQ, 0);
      sample();
      exp_sig(S_IRQ, 1); exp_sig(S_BUSY, 0); exp_sig(S_DIR, 32'h1);
      sample();
      apb_wr(A_STAT, 32'h2, 1'b0);
      exp_sig(S_IRQ, 0);
      sample();

      // Reset during SETTLE, then a fresh sequence
      apb_wr(A_DEAD, 32'h5, 1'b0);
      apb_wr(A_AFC, 32'hFF, 1'b0);
      apb_wr(A_DIR, 32'h2, 1'b0);
      apb_wr(A_CTRL, 32'h1, 1'b0);                    // E0
      cyc(7);
      exp_sig(S_AFC, 32'hFF); exp_sig(S_BUSY, 1); exp_sig(S_DIR, 0);
      sample();                                        // after E0+7, in SETTLE
      PRESETn = 1'b0;
      #2;
      exp_sig(S_AFC, 0); exp_sig(S_DIR, 0); exp_sig(S_PM, 0); exp_sig(S_PS, 0);
      exp_sig(S_BUSY, 0); exp_sig(S_IRQ, 0);
      sample();
      PRESETn = 1'b1;
      apb_rd(A_DEAD, 32'h4);
      apb_rd(A_STAT, 32'h0);
      apb_rd(A_AFC, 32'h0);
      apb_wr(A_DEAD, 32'h1, 1'b0);
      apb_wr(A_AFC, 32'h3, 1'b0);
      apb_wr(A_DIR, 32'h3, 1'b0);
      apb_wr(A_CTRL, 32'h1, 1'b0);                    // E0
      cyc(2);
      exp_sig(S_AFC, 32'h3); exp_sig(S_BUSY, 1); exp_sig(S_DIR, 0);
      sample();                                        // after E0+2
      exp_sig(S_BUSY, 1); exp_sig(S_DIR, 0);
      sample();                                        // after E0+3
      exp_sig(S_DIR, 32'h3); exp_sig(S_BUSY, 0); exp_sig(S_AFC, 32'h3);
      sample();                                        // after E0+4
      apb_rd(A_STAT, 32'h2);

      cyc(2);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
